// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU core: one shared ALU sequenced by a FETCH/DECODE/EXECUTE/WRITEBACK FSM,
// with conditional branches, an absorbing HALT state and a retired-instruction counter.
module multicycle_cpu #(
    parameter int WIDTH = 16,
    parameter int NREGS = 4
) (
    input  logic             clock,
    input  logic             reset,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [15:0]      imem_data,
    output logic [WIDTH-1:0] pc,
    output logic [15:0]      ir,
    output logic [WIDTH-1:0] alu_out,
    output logic [2:0]       state,
    output logic             halted,
    output logic [WIDTH-1:0] retired
);
    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] alu_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] retired_r;
    logic [15:0]      ir_r;
    logic             halted_r;
    logic [WIDTH-1:0] rf_r [1:NREGS-1];

    logic [3:0]       op_s;
    logic [1:0]       rs_s;
    logic [1:0]       rt_s;
    logic [1:0]       rd_s;
    logic [1:0]       wb_idx_s;
    logic [WIDTH-1:0] imm_sext_s;
    logic [WIDTH-1:0] rs_val_s;
    logic [WIDTH-1:0] rt_val_s;
    logic [WIDTH-1:0] alu_res_s;
    logic [WIDTH-1:0] br_target_s;
    logic             is_halt_s;
    logic             is_alu_s;
    logic             is_addi_s;
    logic             is_branch_s;
    logic             taken_s;

    assign op_s        = ir_r[15:12];
    assign rs_s        = ir_r[11:10];
    assign rt_s        = ir_r[9:8];
    assign rd_s        = ir_r[7:6];
    assign imm_sext_s  = {{(WIDTH-8){ir_r[7]}}, ir_r[7:0]};
    assign is_halt_s   = (ir_r == 16'hFFFF);
    assign is_alu_s    = ~op_s[3];
    assign is_addi_s   = (op_s == 4'h7);
    assign is_branch_s = (op_s == 4'h8) || (op_s == 4'h9);
    assign wb_idx_s    = is_addi_s ? rt_s : rd_s;
    // pc already points past the branch, so the offset is added to instruction address + 2
    assign br_target_s = pc_r + {imm_sext_s[WIDTH-2:0], 1'b0};

    // Register file read ports; R0 is hardwired to zero
    always_comb begin
        rs_val_s = {WIDTH{1'b0}};
        rt_val_s = {WIDTH{1'b0}};
        case (rs_s)
            2'd1:    rs_val_s = rf_r[2'd1];
            2'd2:    rs_val_s = rf_r[2'd2];
            2'd3:    rs_val_s = rf_r[2'd3];
            default: rs_val_s = {WIDTH{1'b0}};
        endcase
        case (rt_s)
            2'd1:    rt_val_s = rf_r[2'd1];
            2'd2:    rt_val_s = rf_r[2'd2];
            2'd3:    rt_val_s = rf_r[2'd3];
            default: rt_val_s = {WIDTH{1'b0}};
        endcase
    end

    // Shared ALU and branch condition
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        case (op_s)
            4'h0:       alu_res_s = a_r + b_r;
            4'h1:       alu_res_s = a_r - b_r;
            4'h2:       alu_res_s = a_r & b_r;
            4'h3:       alu_res_s = a_r | b_r;
            4'h4:       alu_res_s = ~(a_r | b_r);
            4'h5:       alu_res_s = ~(a_r & b_r);
            4'h6:       alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
            4'h7:       alu_res_s = a_r + b_r;
            4'h8, 4'h9: alu_res_s = a_r - b_r;
            default:    alu_res_s = {WIDTH{1'b0}};
        endcase
        if (op_s == 4'h8) begin
            taken_s = (alu_res_s == {WIDTH{1'b0}});
        end else begin
            taken_s = (alu_res_s != {WIDTH{1'b0}});
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_FETCH: next_state_s = S_DECODE;
            S_DECODE: begin
                if (is_halt_s) begin
                    next_state_s = S_HALT;
                end else if (is_alu_s || is_branch_s) begin
                    next_state_s = S_EXECUTE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_EXECUTE: begin
                if (is_branch_s) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_WRITEBACK;
                end
            end
            S_WRITEBACK: next_state_s = S_FETCH;
            S_HALT:      next_state_s = S_HALT;
            default:     next_state_s = S_FETCH;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Datapath registers sequenced by the FSM; everything holds in HALT
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_r      <= {WIDTH{1'b0}};
            ir_r      <= 16'h0000;
            alu_r     <= {WIDTH{1'b0}};
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            retired_r <= {WIDTH{1'b0}};
            halted_r  <= 1'b0;
        end else begin
            halted_r <= (next_state_s == S_HALT);
            case (state_r)
                S_FETCH: begin
                    ir_r <= imem_data;
                    pc_r <= pc_r + {{(WIDTH-2){1'b0}}, 2'd2};
                end
                S_DECODE: begin
                    a_r <= rs_val_s;
                    b_r <= is_addi_s ? imm_sext_s : rt_val_s;
                    if (!is_halt_s && !is_alu_s && !is_branch_s) begin
                        retired_r <= retired_r + {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                S_EXECUTE: begin
                    alu_r <= alu_res_s;
                    if (is_branch_s) begin
                        retired_r <= retired_r + {{(WIDTH-1){1'b0}}, 1'b1};
                        if (taken_s) begin
                            pc_r <= br_target_s;
                        end
                    end
                end
                S_WRITEBACK: retired_r <= retired_r + {{(WIDTH-1){1'b0}}, 1'b1};
                default: ;
            endcase
        end
    end

    // Register file write port; writes to R0 are dropped
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                rf_r[i] <= {WIDTH{1'b0}};
            end
        end else if ((state_r == S_WRITEBACK) && (wb_idx_s != 2'd0)) begin
            rf_r[wb_idx_s] <= alu_r;
        end
    end

    assign imem_addr = pc_r;
    assign pc        = pc_r;
    assign ir        = ir_r;
    assign alu_out   = alu_r;
    assign state     = state_r;
    assign halted    = halted_r;
    assign retired   = retired_r;
endmodule

// File: tb/tb_multicycle_cpu.sv
// Self-checking bench for multicycle_cpu: an instruction-level reference model predicts
// the architectural state at each instruction boundary for WIDTH=16 and WIDTH=32 cores.
module tb_multicycle_cpu;
    logic        clock;
    logic        rst16;
    logic        rst32;
    logic [15:0] mem [64];

    logic [15:0] addr16, pc16, alu16, ret16, data16, ir16;
    logic [2:0]  st16;
    logic        hl16;
    logic [31:0] addr32, pc32, alu32, ret32;
    logic [15:0] data32, ir32;
    logic [2:0]  st32;
    logic        hl32;

    int total = 0;
    int bad   = 0;

    int          sel;
    logic [63:0] o_pc, o_addr, o_alu, o_ret;
    logic [15:0] o_ir;
    logic [2:0]  o_state;
    logic        o_halted;

    logic [63:0] mask;
    int          wbits;
    logic [63:0] m_regs [4];
    logic [63:0] m_pc, m_alu, m_ret;
    logic [15:0] m_ir;
    logic        m_halt;

    assign data16 = mem[addr16[6:1]];
    assign data32 = mem[addr32[6:1]];

    multicycle_cpu #(.WIDTH(16), .NREGS(4)) u_dut16 (
        .clock(clock), .reset(rst16), .imem_addr(addr16), .imem_data(data16),
        .pc(pc16), .ir(ir16), .alu_out(alu16), .state(st16), .halted(hl16), .retired(ret16)
    );

    multicycle_cpu #(.WIDTH(32), .NREGS(4)) u_dut32 (
        .clock(clock), .reset(rst32), .imem_addr(addr32), .imem_data(data32),
        .pc(pc32), .ir(ir32), .alu_out(alu32), .state(st32), .halted(hl32), .retired(ret32)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        if (sel == 1) begin
            o_pc = {32'd0, pc32}; o_addr = {32'd0, addr32}; o_alu = {32'd0, alu32};
            o_ret = {32'd0, ret32}; o_ir = ir32; o_state = st32; o_halted = hl32;
        end else begin
            o_pc = {48'd0, pc16}; o_addr = {48'd0, addr16}; o_alu = {48'd0, alu16};
            o_ret = {48'd0, ret16}; o_ir = ir16; o_state = st16; o_halted = hl16;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s (w=%0d) got=%h exp=%h at %0t", tag, wbits, got, exp, $time);
        end
    endtask

    task automatic check_arch();
        check_eq("state", {61'd0, o_state}, m_halt ? 64'd4 : 64'd0);
        check_eq("halted", {63'd0, o_halted}, {63'd0, m_halt});
        check_eq("pc", o_pc, m_pc);
        check_eq("imem_addr", o_addr, m_pc);
        check_eq("ir", {48'd0, o_ir}, {48'd0, m_ir});
        check_eq("alu_out", o_alu, m_alu);
        check_eq("retired", o_ret, m_ret);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_pc"}, o_pc, 64'd0);
        check_eq({tag, "_ir"}, {48'd0, o_ir}, 64'd0);
        check_eq({tag, "_alu"}, o_alu, 64'd0);
        check_eq({tag, "_state"}, {61'd0, o_state}, 64'd0);
        check_eq({tag, "_halted"}, {63'd0, o_halted}, 64'd0);
        check_eq({tag, "_retired"}, o_ret, 64'd0);
    endtask

    // Holds both cores in reset, checks reset values, then releases the selected one at a negedge.
    task automatic do_reset(input int which);
        sel   = which;
        wbits = (which == 1) ? 32 : 16;
        mask  = (64'd1 << wbits) - 64'd1;
        rst16 = 1'b1;
        rst32 = 1'b1;
        #1;
        check_reset_vals("rst");
        repeat (2) @(negedge clock);
        for (int i = 0; i < 4; i++) m_regs[i] = 64'd0;
        m_pc = 64'd0; m_alu = 64'd0; m_ret = 64'd0; m_ir = 16'h0000; m_halt = 1'b0;
        if (which == 1) rst32 = 1'b0;
        else            rst16 = 1'b0;
    endtask

    // Executes one whole instruction in the reference model; returns its cycle count.
    task automatic model_step(output int cyc);
        logic [15:0] w;
        logic [3:0]  op;
        logic [63:0] a, b, s, r, sb;
        int rs, rt, rd, dest;
        w  = mem[m_pc[6:1]];
        m_ir = w;
        m_pc = (m_pc + 64'd2) & mask;
        op = w[15:12];
        rs = int'(w[11:10]); rt = int'(w[9:8]); rd = int'(w[7:6]);
        s  = {{56{w[7]}}, w[7:0]} & mask;
        a  = m_regs[rs];
        b  = m_regs[rt];
        sb = 64'd1 << (wbits - 1);
        r  = 64'd0;
        if (w == 16'hFFFF) begin
            m_halt = 1'b1;
            cyc = 2;
        end else if (op <= 4'd7) begin
            case (op)
                4'd0: r = a + b;
                4'd1: r = a - b;
                4'd2: r = a & b;
                4'd3: r = a | b;
                4'd4: r = ~(a | b);
                4'd5: r = ~(a & b);
                4'd6: r = ((a ^ sb) < (b ^ sb)) ? 64'd1 : 64'd0;
                default: r = a + s;
            endcase
            m_alu = r & mask;
            dest = (op == 4'd7) ? rt : rd;
            if (dest != 0) m_regs[dest] = m_alu;
            m_ret = (m_ret + 64'd1) & mask;
            cyc = 4;
        end else if (op == 4'd8 || op == 4'd9) begin
            m_alu = (a - b) & mask;
            if ((op == 4'd8) == (m_alu == 64'd0)) m_pc = (m_pc + (s << 1)) & mask;
            m_ret = (m_ret + 64'd1) & mask;
            cyc = 3;
        end else begin
            m_ret = (m_ret + 64'd1) & mask;
            cyc = 2;
        end
    endtask

    task automatic run(input int n);
        int cyc;
        for (int i = 0; i < n; i++) begin
            if (m_halt) break;
            model_step(cyc);
            repeat (cyc) @(negedge clock);
            check_arch();
            if (m_halt) begin
                repeat (20) @(negedge clock);
                check_arch();
            end
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 16'hA000;
    endtask

    function automatic logic [15:0] rand_word();
        int r;
        logic [15:0] w;
        r = $urandom_range(0, 99);
        w = 16'($urandom);
        if (r < 2) begin
            w = 16'hFFFF;
        end else if (r < 25) begin
            w[15:12] = 4'h7;
        end else if (r < 70) begin
            w[15:12] = 4'($urandom_range(0, 6));
        end else if (r < 85) begin
            w[15:12] = 4'($urandom_range(8, 9));
            w[7:0]   = 8'($urandom_range(0, 15)) - 8'd8;
        end
        return w;
    endfunction

    initial begin
        sel = 0; wbits = 16; mask = 64'hFFFF;
        rst16 = 1'b1; rst32 = 1'b1;
        clear_mem();

        // Reset in the middle of an add's EXECUTE
        mem[0] = 16'h7105; mem[1] = 16'h0540; mem[2] = 16'h0480;
        do_reset(0);
        #1 check_reset_vals("release");
        run(1);
        repeat (2) @(negedge clock);
        check_eq("exec_state", {61'd0, o_state}, 64'd2);
        #1 rst16 = 1'b1;
        #1 check_reset_vals("midexec");
        do_reset(0);
        run(3);
        check_eq("rerun_r2", o_alu, 64'd10);

        // Arithmetic sequence
        clear_mem();
        mem[0] = 16'h710F; mem[1] = 16'h7207; mem[2] = 16'h16C0;
        do_reset(0);
        run(3);
        check_eq("seq_alu", o_alu, 64'd8);
        check_eq("seq_retired", o_ret, 64'd3);
        check_eq("seq_pc", o_pc, 64'd6);

        // Signed compare
        clear_mem();
        mem[0] = 16'h71FF; mem[1] = 16'h7201; mem[2] = 16'h66C0; mem[3] = 16'h69C0;
        do_reset(0);
        run(3);
        check_eq("slt_lt", o_alu, 64'd1);
        run(1);
        check_eq("slt_ge", o_alu, 64'd0);

        // Branches: beq taken, bne not taken, backward beq
        for (int v = 0; v < 3; v++) begin
            logic [15:0] br_words [3];
            logic [63:0] br_pcs [3];
            br_words = '{16'h8602, 16'h9602, 16'h86FE};
            br_pcs   = '{64'd10, 64'd6, 64'd2};
            clear_mem();
            mem[0] = 16'h7105; mem[1] = 16'h7205; mem[2] = br_words[v];
            do_reset(0);
            run(3);
            check_eq("br_pc", o_pc, br_pcs[v]);
        end

        // Halt at pc=8 after four nops, then resume through reset
        clear_mem();
        mem[4] = 16'hFFFF;
        do_reset(0);
        run(5);
        check_eq("halt_flag", {63'd0, o_halted}, 64'd1);
        check_eq("halt_pc", o_pc, 64'd10);
        check_eq("halt_retired", o_ret, 64'd4);
        do_reset(0);
        #1 check_eq("resume_pc", o_pc, 64'd0);
        run(1);
        check_eq("resume_pc2", o_pc, 64'd2);

        // WIDTH=32 sign extension, doubling and R0 immunity
        clear_mem();
        mem[0] = 16'h71FF; mem[1] = 16'h0540; mem[2] = 16'h0500; mem[3] = 16'h0080;
        do_reset(1);
        run(1);
        check_eq("w32_sext", o_alu, 64'hFFFF_FFFF);
        run(1);
        check_eq("w32_dbl", o_alu, 64'hFFFF_FFFE);
        run(2);
        check_eq("w32_r0", o_alu, 64'd0);

        // Random programs on both widths
        for (int w = 0; w < 2; w++) begin
            for (int p = 0; p < 6; p++) begin
                for (int i = 0; i < 64; i++) mem[i] = rand_word();
                do_reset(w);
                run(120);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
